// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg -- shared constants and types for the decode/issue slice.
//
// Contents:
//   CPU_WIDTH  default datapath width (bits)
//   CPU_NUM    default architectural register count
//   CPU_AW     register-index width derived from CPU_NUM
//   reg_idx_t  register-index type at the default configuration
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int CPU_NUM   = 32;
    localparam int CPU_AW    = $clog2(CPU_NUM);

    typedef logic [CPU_AW-1:0] reg_idx_t;

endpackage : cpu_pkg

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard -- one pending bit per architectural register.
//
// A bit is pending between the issue of an instruction that writes that
// register and the writeback of the value. Register 0 is hard-wired zero and
// never becomes pending.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   set_en_i / set_idx_i      mark a destination as pending (issue)
//   clr_a_en_i / clr_a_idx_i  clear a pending bit (writeback)
//   clr_b_en_i / clr_b_idx_i  clear a pending bit (squashed instruction)
//   query_*_idx_i             combinational lookup indices
//   *_pend_o                  pending state of the queried registers
//
// A set and a clear on the same index in one cycle leaves the bit set: the
// newly issued writer still owes a result.
// -----------------------------------------------------------------------------
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM = CPU_NUM,
    parameter int AW  = $clog2(NUM)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_idx_i,
    input  logic          clr_a_en_i,
    input  logic [AW-1:0] clr_a_idx_i,
    input  logic          clr_b_en_i,
    input  logic [AW-1:0] clr_b_idx_i,
    input  logic [AW-1:0] query_rs1_idx_i,
    input  logic [AW-1:0] query_rs2_idx_i,
    input  logic [AW-1:0] query_rd_idx_i,
    output logic          rs1_pend_o,
    output logic          rs2_pend_o,
    output logic          rd_pend_o
);

    logic [NUM-1:0] pending_q;
    logic [NUM-1:0] pending_d;

    always_comb begin
        // NOTE: start from the held value so every path assigns pending_d;
        // a missing default here would infer a latch.
        pending_d = pending_q;
        if (clr_a_en_i) pending_d[clr_a_idx_i] = 1'b0;
        if (clr_b_en_i) pending_d[clr_b_idx_i] = 1'b0;
        // Set is applied last so it wins over a same-cycle clear.
        if (set_en_i)   pending_d[set_idx_i]   = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        // NOTE: pending bits are flops, not a RAM, and must be reset: a stale
        // bit after reset would stall its readers forever.
        if (reset) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_pend_o = pending_q[query_rs1_idx_i];
    assign rs2_pend_o = pending_q[query_rs2_idx_i];
    assign rd_pend_o  = pending_q[query_rd_idx_i];

endmodule : reg_scoreboard

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch -- register read / hazard check stage between decode and
// execute, with a single output register (latency 1).
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready          decoded instruction handshake
//   in_rs1, in_rs2, in_rd        register indices; in_rd_we marks a writer
//   rf_addr_r1/r2, rf_data_r1/r2 asynchronous register-file read port
//   wb_valid, wb_rd, wb_data     writeback; the register file commits at the
//                                same edge
//   flush                        squash the instruction held at the output
//   out_valid / out_ready        execute-stage handshake
//   out_rs1_val, out_rs2_val     operands; out_rd / out_rd_we passed through
//
// Build option:
//   OPERAND_BYPASS_EN  when defined, a writeback in the current cycle is
//                      forwarded to a matching source and resolves its hazard
//                      immediately. When undefined, a pending source stalls
//                      through its writeback cycle and is read from the
//                      register file on the next cycle.
// -----------------------------------------------------------------------------
module operand_fetch
    import cpu_pkg::*;
#(
    parameter  int WIDTH = CPU_WIDTH,
    parameter  int NUM   = CPU_NUM,
    localparam int AW    = $clog2(NUM)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic [AW-1:0]    in_rd,
    input  logic             in_rd_we,
    output logic [AW-1:0]    rf_addr_r1,
    output logic [AW-1:0]    rf_addr_r2,
    input  logic [WIDTH-1:0] rf_data_r1,
    input  logic [WIDTH-1:0] rf_data_r2,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rs1_val,
    output logic [WIDTH-1:0] out_rs2_val,
    output logic [AW-1:0]    out_rd,
    output logic             out_rd_we
);

`ifdef OPERAND_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] rs1_val;
        logic [WIDTH-1:0] rs2_val;
        logic [AW-1:0]    rd;
        logic             rd_we;
    } out_reg_t;

    out_reg_t out_q;
    out_reg_t out_d;

    logic rs1_pend, rs2_pend, rd_pend;
    logic wb_hits_rs1, wb_hits_rs2, wb_hits_rd;
    logic rs1_hazard, rs2_hazard, rd_hazard;
    logic accept;
    logic sb_set_en;
    logic sb_flush_clr;
    logic [WIDTH-1:0] rs1_val, rs2_val;

    // The register file is read combinationally from the decoded indices.
    assign rf_addr_r1 = in_rs1;
    assign rf_addr_r2 = in_rs2;

    // A writeback this cycle can only resolve a hazard when it is forwarded.
    assign wb_hits_rs1 = BYPASS && wb_valid && (wb_rd == in_rs1);
    assign wb_hits_rs2 = BYPASS && wb_valid && (wb_rd == in_rs2);
    assign wb_hits_rd  = BYPASS && wb_valid && (wb_rd == in_rd);

    assign rs1_hazard = (in_rs1 != '0) && rs1_pend && !wb_hits_rs1;
    assign rs2_hazard = (in_rs2 != '0) && rs2_pend && !wb_hits_rs2;
    assign rd_hazard  = in_rd_we && rd_pend && !wb_hits_rd;

    // Independent of in_valid so the upstream stage may wait on in_ready.
    assign in_ready = !reset && !flush
                    && !(rs1_hazard || rs2_hazard || rd_hazard)
                    && (!out_q.valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Operand priority: x0, then forwarded writeback, then register file.
    assign rs1_val = (in_rs1 == '0) ? '0 : (wb_hits_rs1 ? wb_data : rf_data_r1);
    assign rs2_val = (in_rs2 == '0) ? '0 : (wb_hits_rs2 ? wb_data : rf_data_r2);

    // Issue marks the destination pending; a squashed instruction gives its
    // destination back. rd=0 is filtered inside the scoreboard as well.
    assign sb_set_en    = accept && in_rd_we && (in_rd != '0);
    assign sb_flush_clr = flush && out_q.valid && out_q.rd_we;

    reg_scoreboard #(
        .NUM (NUM),
        .AW  (AW)
    ) u_scoreboard (
        .clock           (clock),
        .reset           (reset),
        .set_en_i        (sb_set_en),
        .set_idx_i       (in_rd),
        .clr_a_en_i      (wb_valid),
        .clr_a_idx_i     (wb_rd),
        .clr_b_en_i      (sb_flush_clr),
        .clr_b_idx_i     (out_q.rd),
        .query_rs1_idx_i (in_rs1),
        .query_rs2_idx_i (in_rs2),
        .query_rd_idx_i  (in_rd),
        .rs1_pend_o      (rs1_pend),
        .rs2_pend_o      (rs2_pend),
        .rd_pend_o       (rd_pend)
    );

    always_comb begin
        out_d = out_q;
        if (accept) begin
            out_d.valid   = 1'b1;
            out_d.rs1_val = rs1_val;
            out_d.rs2_val = rs2_val;
            out_d.rd      = in_rd;
            out_d.rd_we   = in_rd_we;
        end else if (flush || out_ready) begin
            // Drain or squash; the payload is left as-is and ignored.
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_valid   = out_q.valid;
    assign out_rs1_val = out_q.rs1_val;
    assign out_rs2_val = out_q.rs2_val;
    assign out_rd      = out_q.rd;
    assign out_rd_we   = out_q.rd_we;

endmodule : operand_fetch
